// File: rtl/io_ctl_gen.sv
// io_ctl_gen: memory-mapped I/O controller between the CPU memory stage and
// the board pins. Accesses with ADDR[31]=1 hit a 32-bit register file for
// LEDs, switches, a tristate GPIO port and a multiplexed 7-segment display.
// Optional feature: define IOCTL_GEN_EDGE_IRQ_EN to add per-bit GPIO
// edge-capture interrupts (IRQ_MASK/IRQ_PEND/IRQ_POL at 0x08..0x0A).
module io_ctl_gen #(
    parameter int GPIO_W     = 16,
    parameter int SSG_DIGITS = 6,
    parameter int SSG_DIV    = 50000,
    parameter int SW_W       = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           ADDR,
    input  logic [31:0]           DIN,
    input  logic                  WE,
    input  logic                  RREQ,
    output logic [31:0]           DO,
    output logic                  RDY,
    input  logic [SW_W-1:0]       SW,
    output logic [7:0]            LED,
    inout  wire  [GPIO_W-1:0]     GPIO,
    output logic [7:0]            SSGD,
    output logic [SSG_DIGITS-1:0] SSGS,
    output logic                  IRQ
);
    localparam int IDX_W = (SSG_DIGITS > 1) ? $clog2(SSG_DIGITS) : 1;
    localparam int CNT_W = $clog2(SSG_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    start_s, wr_s, rd_s, rdy_d;
    logic [7:0]              addr_q;
    logic [31:0]             din_q;
    logic                    we_q;
    logic [31:0]             do_q, rd_data_s;
    logic                    rdy_q;
    logic [SW_W-1:0]         sw_q;
    logic [7:0]              led_q;
    logic [GPIO_W-1:0]       mode_q, out_q, sync1_q, sync2_q;
    logic                    en_q;
    logic [7:0]              seg_q [SSG_DIGITS];
    logic                    run_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q, idx_nx_s;
    logic [SSG_DIGITS-1:0]   ssgs_q, sel_s, first_sel_s;
    logic [7:0]              ssgd_q;
    logic                    unused_s;

    assign unused_s = ^{ADDR[30:8], din_q};
    assign start_s  = (state_q == ST_IDLE) && ADDR[31] && (WE || RREQ);

    // Bus FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Bus FSM next-state logic; requests only start from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_ACCESS;
                else         state_d = ST_IDLE;
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus FSM outputs: the latched operation executes in ACCESS.
    always_comb begin
        wr_s  = 1'b0;
        rd_s  = 1'b0;
        rdy_d = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                wr_s  = we_q;
                rd_s  = ~we_q;
                rdy_d = 1'b1;
            end
            default: begin
                wr_s  = 1'b0;
                rd_s  = 1'b0;
                rdy_d = 1'b0;
            end
        endcase
    end

    // Latch register index, data and operation (WE wins over RREQ).
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= 8'h00;
            din_q  <= 32'h0000_0000;
            we_q   <= 1'b0;
        end else if (start_s) begin
            addr_q <= ADDR[7:0];
            din_q  <= DIN;
            we_q   <= WE;
        end
    end

    // Read data and completion pulse; DO only changes on a completed read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            do_q  <= 32'h0000_0000;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy_d;
            if (rd_s) do_q <= rd_data_s;
        end
    end

    // Switch sampling and two-flop GPIO input synchroniser.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_q    <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sw_q    <= SW;
            sync1_q <= GPIO;
            sync2_q <= sync1_q;
        end
    end

    // Control register writes; only the register width is stored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q  <= 8'h00;
            mode_q <= '0;
            out_q  <= '0;
            en_q   <= 1'b0;
        end else if (wr_s) begin
            case (addr_q)
                8'h01:   led_q  <= din_q[7:0];
                8'h02:   mode_q <= din_q[GPIO_W-1:0];
                8'h04:   out_q  <= din_q[GPIO_W-1:0];
                8'h05:   en_q   <= din_q[0];
                default: ;
            endcase
        end
    end

    // Segment pattern register writes, one per digit.
    always_ff @(posedge CLK) begin
        for (int d = 0; d < SSG_DIGITS; d++) begin
            if (RST) seg_q[d] <= 8'h00;
            else if (wr_s && (addr_q == (8'h10 + 8'(d)))) seg_q[d] <= din_q[7:0];
        end
    end

`ifdef IOCTL_GEN_EDGE_IRQ_EN
    logic [GPIO_W-1:0] mask_q, pend_q, pol_q, prev_q, edge_s, w1c_s;
    logic              irq_q;

    // Edge detect on input-mode bits and write-1-to-clear mask.
    always_comb begin
        edge_s = ~mode_q & ((pol_q & sync2_q & ~prev_q) | (~pol_q & ~sync2_q & prev_q));
        if (wr_s && (addr_q == 8'h09)) w1c_s = din_q[GPIO_W-1:0];
        else                           w1c_s = '0;
    end

    // Interrupt registers; a new edge beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mask_q <= '0;
            pol_q  <= '1;
            pend_q <= '0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            pend_q <= (pend_q & ~w1c_s) | edge_s;
            irq_q  <= |(pend_q & mask_q);
            if (wr_s && (addr_q == 8'h08)) mask_q <= din_q[GPIO_W-1:0];
            if (wr_s && (addr_q == 8'h0A)) pol_q  <= din_q[GPIO_W-1:0];
        end
    end

    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

    // Read multiplexer; anything unmapped reads as all ones.
    always_comb begin
        rd_data_s = 32'hFFFF_FFFF;
        case (addr_q)
            8'h00: begin rd_data_s = 32'h0; rd_data_s[SW_W-1:0]   = sw_q;    end
            8'h01: begin rd_data_s = {24'h0, led_q};                         end
            8'h02: begin rd_data_s = 32'h0; rd_data_s[GPIO_W-1:0] = mode_q;  end
            8'h03: begin rd_data_s = 32'h0; rd_data_s[GPIO_W-1:0] = sync2_q; end
            8'h04: begin rd_data_s = 32'h0; rd_data_s[GPIO_W-1:0] = out_q;   end
            8'h05: begin rd_data_s = {31'h0, en_q};                          end
`ifdef IOCTL_GEN_EDGE_IRQ_EN
            8'h08: begin rd_data_s = 32'h0; rd_data_s[GPIO_W-1:0] = mask_q;  end
            8'h09: begin rd_data_s = 32'h0; rd_data_s[GPIO_W-1:0] = pend_q;  end
            8'h0A: begin rd_data_s = 32'h0; rd_data_s[GPIO_W-1:0] = pol_q;   end
`endif
            default: begin
                for (int d = 0; d < SSG_DIGITS; d++) begin
                    if (addr_q == (8'h10 + 8'(d))) rd_data_s = {24'h0, seg_q[d]};
                    else                           rd_data_s = rd_data_s;
                end
            end
        endcase
    end

    // Next digit index (wrapping) and the matching active-low selects.
    always_comb begin
        if (idx_q == IDX_W'(SSG_DIGITS - 1)) idx_nx_s = '0;
        else                                 idx_nx_s = idx_q + IDX_W'(1);
        sel_s             = '1;
        sel_s[idx_nx_s]   = 1'b0;
        first_sel_s       = '1;
        first_sel_s[0]    = 1'b0;
    end

    // Display scanner: idle when disabled, digit 0 on the first enabled edge.
    always_ff @(posedge CLK) begin
        if (RST || !en_q) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
            ssgs_q <= '1;
            ssgd_q <= 8'h00;
        end else if (!run_q) begin
            run_q  <= 1'b1;
            cnt_q  <= '0;
            idx_q  <= '0;
            ssgs_q <= first_sel_s;
            ssgd_q <= seg_q[0];
        end else if (cnt_q == CNT_W'(SSG_DIV - 1)) begin
            cnt_q  <= '0;
            idx_q  <= idx_nx_s;
            ssgs_q <= sel_s;
            ssgd_q <= seg_q[idx_nx_s];
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio_drv
        assign GPIO[i] = mode_q[i] ? out_q[i] : 1'bz;
    end

    assign DO   = do_q;
    assign RDY  = rdy_q;
    assign LED  = led_q;
    assign SSGD = ssgd_q;
    assign SSGS = ssgs_q;
endmodule

// File: tb/tb_io_ctl_gen.sv
// Randomised self-checking bench for io_ctl_gen (GPIO_W=16, 6 digits,
// SSG_DIV=4) against a register-map model kept in the bench.
module tb_io_ctl_gen;
    logic        CLK, RST;
    logic [31:0] ADDR, DIN, DO;
    logic        WE, RREQ, RDY, IRQ;
    logic [7:0]  SW, LED, SSGD;
    logic [5:0]  SSGS;
    wire  [15:0] GPIO;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_led;
    logic [15:0] m_mode, m_out, m_mask, m_pol, m_pend;
    logic        m_en;
    logic [7:0]  m_seg [6];
    logic [31:0] m_do;
    logic [15:0] tb_pin;

    io_ctl_gen #(.GPIO_W(16), .SSG_DIGITS(6), .SSG_DIV(4), .SW_W(8)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RREQ(RREQ),
        .DO(DO), .RDY(RDY), .SW(SW), .LED(LED), .GPIO(GPIO),
        .SSGD(SSGD), .SSGS(SSGS), .IRQ(IRQ)
    );

    // The bench drives every pin the controller leaves as an input.
    for (genvar i = 0; i < 16; i++) begin : g_pin
        assign GPIO[i] = m_mode[i] ? 1'bz : tb_pin[i];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 8'h00; m_mode = 16'h0; m_out = 16'h0; m_en = 1'b0;
        for (int d = 0; d < 6; d++) m_seg[d] = 8'h00;
        m_do = 32'h0; m_mask = 16'h0; m_pol = 16'hFFFF; m_pend = 16'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] idx);
        logic [15:0] pins;
        pins = (m_mode & m_out) | (~m_mode & tb_pin);
        if (idx == 8'h00) return {24'h0, SW};
        if (idx == 8'h01) return {24'h0, m_led};
        if (idx == 8'h02) return {16'h0, m_mode};
        if (idx == 8'h03) return {16'h0, pins};
        if (idx == 8'h04) return {16'h0, m_out};
        if (idx == 8'h05) return {31'h0, m_en};
`ifdef IOCTL_GEN_EDGE_IRQ_EN
        if (idx == 8'h08) return {16'h0, m_mask};
        if (idx == 8'h09) return {16'h0, m_pend};
        if (idx == 8'h0A) return {16'h0, m_pol};
`endif
        if (idx >= 8'h10 && idx < 8'h16) return {24'h0, m_seg[idx - 8'h10]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_write(input logic [7:0] idx, input logic [31:0] data);
        if (idx == 8'h01) m_led = data[7:0];
        if (idx == 8'h02) m_mode = data[15:0];
        if (idx == 8'h04) m_out = data[15:0];
        if (idx == 8'h05) m_en = data[0];
`ifdef IOCTL_GEN_EDGE_IRQ_EN
        if (idx == 8'h08) m_mask = data[15:0];
        if (idx == 8'h09) m_pend = m_pend & ~data[15:0];
        if (idx == 8'h0A) m_pol = data[15:0];
`endif
        if (idx >= 8'h10 && idx < 8'h16) m_seg[idx - 8'h10] = data[7:0];
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic check_outputs();
        chk("do", DO, m_do);
        chk("led", {24'h0, LED}, {24'h0, m_led});
        chk("gpio", {16'h0, GPIO}, {16'h0, (m_mode & m_out) | (~m_mode & tb_pin)});
        if (!m_en) begin
            chk("ssgs_off", {26'h0, SSGS}, 32'h3F);
            chk("ssgd_off", {24'h0, SSGD}, 32'h0);
        end
`ifndef IOCTL_GEN_EDGE_IRQ_EN
        chk("irq_tied", {31'h0, IRQ}, 32'h0);
`endif
    endtask

    // One bus access: RDY must rise two edges after the request edge and last one cycle.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] data,
                            input logic we, input logic rreq);
        int cyc;
        ADDR = addr; DIN = data; WE = we; RREQ = rreq;
        cyc = 0;
        do begin @(posedge CLK); #1; cyc++; end while (!RDY && cyc < 8);
        WE = 1'b0; RREQ = 1'b0;
        chk("rdy_latency", 32'(cyc), 32'd2);
        if (RDY) begin
            if (we) model_write(addr[7:0], data);
            else    m_do = model_read(addr[7:0]);
        end
        @(posedge CLK); #1;
        chk("rdy_width", {31'h0, RDY}, 32'h0);
        check_outputs();
    endtask

    task automatic wr(input logic [7:0] idx, input logic [31:0] data);
        bus_xfer({24'h800000, idx}, data, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [7:0] idx);
        bus_xfer({24'h800000, idx}, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        wait_cycles(2);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0]  idx;
        logic [31:0] data, upper, exp_sel;
        int kind, cyc, step;
        logic seen;

        RST = 1'b1; ADDR = 32'h0; DIN = 32'h0; WE = 1'b0; RREQ = 1'b0;
        SW = 8'h00; tb_pin = 16'h0;
        model_reset();
        @(posedge CLK); #1;
        do_reset();
        chk("rst_do", DO, 32'h0);
        chk("rst_rdy", {31'h0, RDY}, 32'h0);
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        check_outputs();

        rd(8'h01);
        rd(8'h02);

        // Reset during ACCESS of a write: nothing happens, then normal service.
        ADDR = 32'h8000_0001; DIN = 32'h55; WE = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1; WE = 1'b0;
        seen = 1'b0;
        @(posedge CLK); #1;
        seen = seen | RDY;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin @(posedge CLK); #1; seen = seen | RDY; end
        chk("rst_mid_rdy", {31'h0, seen}, 32'h0);
        chk("rst_mid_led", {24'h0, LED}, 32'h0);
        rd(8'h01);
        wr(8'h01, 32'h5A);

`ifdef IOCTL_GEN_EDGE_IRQ_EN
        wr(8'h09, 32'hFFFF);
        wr(8'h08, 32'h0001);
        wr(8'h0A, 32'h0001);
        tb_pin[0] = 1'b1;
        cyc = 0;
        do begin @(posedge CLK); #1; cyc++; end while (!IRQ && cyc < 8);
        chk("irq_latency", 32'(cyc), 32'd4);
        m_pend = 16'h0001;
        rd(8'h09);
        wr(8'h09, 32'h1);
        chk("irq_clear", {31'h0, IRQ}, 32'h0);
        tb_pin[0] = 1'b0;
        wait_cycles(6);
        chk("irq_fall", {31'h0, IRQ}, 32'h0);
        rd(8'h09);
`endif

        // GPIO output path and read-back through the synchroniser.
        tb_pin = 16'h0;
        wr(8'h04, 32'h0000_00A5);
        wr(8'h02, 32'h0000_00FF);
        chk("gpio_a5", {16'h0, GPIO}, 32'h0000_00A5);
        rd(8'h03);
        chk("gpio_in", DO, 32'h0000_00A5);

        // Unmapped access and WE+RREQ priority.
        rd(8'h7F);
        chk("unmapped_rd", DO, 32'hFFFF_FFFF);
        wr(8'h7F, 32'h1234_5678);
        bus_xfer(32'h8000_0001, 32'h0000_00C3, 1'b1, 1'b1);
        chk("we_prio_led", {24'h0, LED}, 32'hC3);
        chk("we_prio_do", DO, 32'hFFFF_FFFF);
        wr(8'h02, 32'h0);

        // Display scan.
        wr(8'h10, 32'h06); wr(8'h11, 32'h5B); wr(8'h12, 32'h4F);
        wr(8'h13, 32'h66); wr(8'h14, 32'h6D); wr(8'h15, 32'h7D);
        wr(8'h05, 32'h1);
        for (step = 0; step < 13; step++) begin
            if (step > 0) wait_cycles(4);
            exp_sel = 32'h3F & ~(32'd1 << (step % 6));
            chk("ssgs_scan", {26'h0, SSGS}, exp_sel);
            chk("ssgd_scan", {24'h0, SSGD}, {24'h0, m_seg[step % 6]});
        end
        wr(8'h05, 32'h0);

        // Randomised accesses against the model.
        for (int it = 0; it < 150; it++) begin
            tb_pin = 16'($urandom);
            SW = 8'($urandom);
            wait_cycles(3);
            if ($urandom_range(0, 7) == 0) idx = 8'($urandom_range(32, 255));
            else                           idx = 8'($urandom_range(0, 31));
`ifdef IOCTL_GEN_EDGE_IRQ_EN
            if (idx == 8'h09) idx = 8'h06;
`endif
            data  = $urandom;
            upper = $urandom;
            kind  = $urandom_range(0, 9);
            if (kind == 0) begin
                ADDR = {1'b0, upper[30:8], idx}; DIN = data; WE = 1'b1; RREQ = upper[0];
                seen = 1'b0;
                for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; seen = seen | RDY; end
                WE = 1'b0; RREQ = 1'b0;
                chk("non_io_rdy", {31'h0, seen}, 32'h0);
                check_outputs();
            end else begin
                bus_xfer({1'b1, upper[30:8], idx}, data, kind < 5, kind >= 4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
